// File: rtl/i_adap_quan_pkg.sv
// rtl/i_adap_quan_pkg.sv - shared types, widths and G.726 RECONST tables for the inverse adaptive quantizer
// Purpose: rate encodings, bits-per-codeword per rate, the four DQLN tables
//          (indexed by codeword magnitude) and the RECONST helper.
// Ports:   none (package).
package i_adap_quan_pkg;

  localparam int Y_W   = 13;  // G.726 scale factor width
  localparam int I_W   = 5;   // widest codeword (40 kbit/s)
  localparam int DQL_W = 12;  // log-domain values, 2's complement
  localparam int D_W   = 16;  // D[15]=sign, D[14:0]=magnitude
  localparam int MAG_W = 15;

  typedef enum logic [1:0] {
    RATE_40K = 2'd0,
    RATE_32K = 2'd1,
    RATE_24K = 2'd2,
    RATE_16K = 2'd3
  } rate_e;

  typedef struct packed {
    logic             dqs;
    logic [DQL_W-1:0] dqln;
  } reconst_t;

  function automatic logic [2:0] nb_of(input rate_e rate);
    case (rate)
      RATE_40K: nb_of = 3'd5;
      RATE_32K: nb_of = 3'd4;
      RATE_24K: nb_of = 3'd3;
      default:  nb_of = 3'd2;
    endcase
  endfunction

  function automatic logic [DQL_W-1:0] dqln_40k(input logic [3:0] idx);
    case (idx)
      4'd0:  dqln_40k = 12'h800;  // -2048
      4'd1:  dqln_40k = 12'hFBE;  // -66
      4'd2:  dqln_40k = 12'd28;
      4'd3:  dqln_40k = 12'd104;
      4'd4:  dqln_40k = 12'd169;
      4'd5:  dqln_40k = 12'd224;
      4'd6:  dqln_40k = 12'd274;
      4'd7:  dqln_40k = 12'd318;
      4'd8:  dqln_40k = 12'd358;
      4'd9:  dqln_40k = 12'd395;
      4'd10: dqln_40k = 12'd429;
      4'd11: dqln_40k = 12'd459;
      4'd12: dqln_40k = 12'd488;
      4'd13: dqln_40k = 12'd514;
      4'd14: dqln_40k = 12'd539;
      default: dqln_40k = 12'd566;
    endcase
  endfunction

  function automatic logic [DQL_W-1:0] dqln_32k(input logic [2:0] idx);
    case (idx)
      3'd0: dqln_32k = 12'h800;
      3'd1: dqln_32k = 12'd4;
      3'd2: dqln_32k = 12'd135;
      3'd3: dqln_32k = 12'd213;
      3'd4: dqln_32k = 12'd273;
      3'd5: dqln_32k = 12'd323;
      3'd6: dqln_32k = 12'd373;
      default: dqln_32k = 12'd425;
    endcase
  endfunction

  function automatic logic [DQL_W-1:0] dqln_24k(input logic [1:0] idx);
    case (idx)
      2'd0: dqln_24k = 12'h800;
      2'd1: dqln_24k = 12'd135;
      2'd2: dqln_24k = 12'd273;
      default: dqln_24k = 12'd373;
    endcase
  endfunction

  function automatic logic [DQL_W-1:0] dqln_16k(input logic idx);
    dqln_16k = idx ? 12'd365 : 12'd116;
  endfunction

  // Codeword bits above nb-1 never reach the tables, so they cannot affect D.
  function automatic reconst_t reconst(input rate_e rate, input logic [I_W-1:0] i);
    reconst_t r;
    r.dqs = i[nb_of(rate) - 3'd1];
    case (rate)
      RATE_40K: r.dqln = dqln_40k(r.dqs ? ~i[3:0] : i[3:0]);
      RATE_32K: r.dqln = dqln_32k(r.dqs ? ~i[2:0] : i[2:0]);
      RATE_24K: r.dqln = dqln_24k(r.dqs ? ~i[1:0] : i[1:0]);
      default:  r.dqln = dqln_16k(r.dqs ? ~i[0]   : i[0]);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/i_adap_quan_mc_antilog.sv
// rtl/i_adap_quan_mc_antilog.sv - combinational ANTILOG: log-domain DQL to linear magnitude
// Purpose: DQMAG = DS ? 0 : ((DQT<<7) >> (14-DEX)), truncated to 15 bits.
// Ports:   i_dql    in  12  log-domain quantized difference (2's complement)
//          o_dqmag  out 15  linear magnitude
module iaq_antilog
  import i_adap_quan_pkg::*;
(
  input  logic [DQL_W-1:0] i_dql,
  output logic [MAG_W-1:0] o_dqmag
);

  logic       w_ds;
  logic [3:0] w_dex;
  logic [7:0] w_dqt;
  logic [15:0] w_shifted;

  assign w_ds  = i_dql[11];
  assign w_dex = i_dql[10:7];
  assign w_dqt = {1'b1, i_dql[6:0]};

  // One extra bit of headroom turns the shift into a pure right shift, so
  // DEX=15 (a left shift by one) needs no special case before truncation.
  assign w_shifted = {w_dqt, 8'b0} >> (4'd15 - w_dex);
  assign o_dqmag   = w_ds ? '0 : w_shifted[MAG_W-1:0];

endmodule

// File: rtl/i_adap_quan_mc.sv
// rtl/i_adap_quan_mc.sv - multichannel 3-stage pipelined G.726 inverse adaptive quantizer
// Purpose: RECONST -> ADDA -> ANTILOG with per-channel RATE table and valid/ready on both sides.
// Ports:   i_clk, i_rst_n (async active-low)
//          i_in_valid/o_in_ready, i_in_ch, i_i, i_y                 input sample stream
//          i_cfg_we, i_cfg_ch, i_cfg_rate                           RATE table write
//          o_out_valid/i_out_ready, o_out_ch, o_d, o_out_rate       output sample stream
module i_adap_quan_mc
  import i_adap_quan_pkg::*;
#(
  parameter int NUM_CH = 32,
  parameter int CH_W   = 5
)
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [CH_W-1:0]  i_in_ch,
  input  logic [I_W-1:0]   i_i,
  input  logic [Y_W-1:0]   i_y,
  input  logic             i_cfg_we,
  input  logic [CH_W-1:0]  i_cfg_ch,
  input  logic [1:0]       i_cfg_rate,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [CH_W-1:0]  o_out_ch,
  output logic [D_W-1:0]   o_d,
  output logic [1:0]       o_out_rate
);

  logic [1:0] r_rate_tbl [NUM_CH];

  logic             r_s1_valid, r_s2_valid, r_s3_valid;
  logic             r_s1_dqs, r_s2_dqs;
  logic [DQL_W-1:0] r_s1_dqln, r_s2_dql;
  logic [10:0]      r_s1_yq;
  logic [CH_W-1:0]  r_s1_ch, r_s2_ch, r_s3_ch;
  rate_e            r_s1_rate, r_s2_rate, r_s3_rate;
  logic [D_W-1:0]   r_s3_d;

  logic             w_s1_en, w_s2_en, w_s3_en;
  rate_e            w_rate;
  reconst_t         w_rec;
  logic [MAG_W-1:0] w_dqmag;
  logic             w_unused;

  // Y[1:0] are below the resolution ADDA works at.
  assign w_unused = &{1'b0, i_y[1:0]};

  // A stage may load when it is empty or its contents move on this cycle.
  assign w_s3_en    = ~r_s3_valid | i_out_ready;
  assign w_s2_en    = ~r_s2_valid | w_s3_en;
  assign w_s1_en    = ~r_s1_valid | w_s2_en;
  assign o_in_ready = w_s1_en;

  // Combinational read of the table: a write in the accept cycle lands after
  // this sample has already picked up the old rate.
  assign w_rate = (int'(i_in_ch) < NUM_CH) ? rate_e'(r_rate_tbl[i_in_ch]) : RATE_32K;
  assign w_rec  = reconst(w_rate, i_i);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NUM_CH; k++) r_rate_tbl[k] <= RATE_32K;
    end else if (i_cfg_we && (int'(i_cfg_ch) < NUM_CH)) begin
      r_rate_tbl[i_cfg_ch] <= i_cfg_rate;
    end
  end

  // S1 RECONST
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_dqs   <= 1'b0;
      r_s1_dqln  <= '0;
      r_s1_yq    <= '0;
      r_s1_ch    <= '0;
      r_s1_rate  <= RATE_32K;
    end else if (w_s1_en) begin
      r_s1_valid <= i_in_valid;
      if (i_in_valid) begin
        r_s1_dqs  <= w_rec.dqs;
        r_s1_dqln <= w_rec.dqln;
        r_s1_yq   <= i_y[12:2];
        r_s1_ch   <= i_in_ch;
        r_s1_rate <= w_rate;
      end
    end
  end

  // S2 ADDA: 12-bit modulo add, carry discarded
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_dqs   <= 1'b0;
      r_s2_dql   <= '0;
      r_s2_ch    <= '0;
      r_s2_rate  <= RATE_32K;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_dqs  <= r_s1_dqs;
        r_s2_dql  <= r_s1_dqln + {1'b0, r_s1_yq};
        r_s2_ch   <= r_s1_ch;
        r_s2_rate <= r_s1_rate;
      end
    end
  end

  iaq_antilog u_antilog (
    .i_dql   (r_s2_dql),
    .o_dqmag (w_dqmag)
  );

  // S3 ANTILOG result; held while the consumer stalls
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s3_valid <= 1'b0;
      r_s3_d     <= '0;
      r_s3_ch    <= '0;
      r_s3_rate  <= RATE_40K;
    end else if (w_s3_en) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_d    <= {r_s2_dqs, w_dqmag};
        r_s3_ch   <= r_s2_ch;
        r_s3_rate <= r_s2_rate;
      end
    end
  end

  assign o_out_valid = r_s3_valid;
  assign o_d         = r_s3_d;
  assign o_out_ch    = r_s3_ch;
  assign o_out_rate  = r_s3_rate;

endmodule
